// File: rtl/sa48_slice_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa48_slice_sequencer : streams a 48-bit operand pair as four 12-bit slices
// into the slice-serial adder datapath and returns the assembled result.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sa48_slice_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [47:0] opA,
  input  logic [47:0] opB,
  input  logic        ciIn,
  input  logic        abort,
  output logic [11:0] inBusA,
  output logic [11:0] inBusB,
  output logic        threeNybblesFlag1,
  output logic        threeNybblesFlag2,
  output logic        threeNybblesFlag3,
  output logic        threeNybblesFlag4,
  output logic        loadReady,
  output logic        ci48,
  input  logic [47:0] sumIn,
  input  logic        coIn,
  output logic [47:0] result,
  output logic        carryOut,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SL1  = 3'd1,
    S_SL2  = 3'd2,
    S_SL3  = 3'd3,
    S_SL4  = 3'd4,
    S_LOAD = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [3:0] C_LAST = 4'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [47:0] r_op_a;
  logic [47:0] r_op_b;
  logic [47:0] r_result;
  logic        r_ci;
  logic        r_carry;
  logic        w_last;

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_ci     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_op_a  <= opA;
            r_op_b  <= opB;
            r_ci    <= ciIn;
            r_cnt   <= '0;
            r_state <= S_SL1;
          end
        end
        S_SL1, S_SL2, S_SL3, S_SL4, S_LOAD: begin
          if (abort) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_cnt <= '0;
            // datapath carry is only meaningful while a slice flag is high
            if (r_state == S_SL4) r_carry <= coIn;
            if (r_state == S_LOAD) r_result <= sumIn;
            r_state <= state_t'(r_state + 3'd1);
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          if (abort || result_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    inBusA = '0;
    inBusB = '0;
    case (r_state)
      S_SL1: begin inBusA = r_op_a[11:0];  inBusB = r_op_b[11:0];  end
      S_SL2: begin inBusA = r_op_a[23:12]; inBusB = r_op_b[23:12]; end
      S_SL3: begin inBusA = r_op_a[35:24]; inBusB = r_op_b[35:24]; end
      S_SL4: begin inBusA = r_op_a[47:36]; inBusB = r_op_b[47:36]; end
      default: begin inBusA = '0; inBusB = '0; end
    endcase
  end

  assign threeNybblesFlag1 = (r_state == S_SL1);
  assign threeNybblesFlag2 = (r_state == S_SL2);
  assign threeNybblesFlag3 = (r_state == S_SL3);
  assign threeNybblesFlag4 = (r_state == S_SL4);
  assign loadReady         = (r_state == S_LOAD);
  assign result_valid      = (r_state == S_DONE);
  assign start_ready       = (r_state == S_IDLE);
  assign busy              = (r_state != S_IDLE);
  assign ci48              = (r_state != S_IDLE) && r_ci;
  assign result            = r_result;
  assign carryOut          = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_sa48_slice_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sa48_slice_sequencer : directed + random operations on H=1 and H=3
// sequencers, each driving a behavioural slice-serial adder datapath.
// ---------------------------------------------------------------------------
module tb_sa48_slice_sequencer;

  localparam int H1 = 1;
  localparam int H3 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sv1 = 1'b0, sv3 = 1'b0;
  logic [47:0] opA = '0, opB = '0;
  logic        ciIn = 1'b0, abort = 1'b0, result_ready = 1'b0;
  bit          sel = 1'b0;

  int checks = 0;
  int failures = 0;

  logic        sr1, lr1, ci1, co1, cy1, rv1, busy1;
  logic        sr3, lr3, ci3, co3, cy3, rv3, busy3;
  logic [3:0]  fl1, fl3;
  logic [11:0] ba1, bb1, ba3, bb3;
  logic [47:0] sum1, res1, sum3, res3;
  logic [48:0] dp1, dp3;
  logic [47:0] capA1 = '0, capB1 = '0, capA3 = '0, capB3 = '0;

  always #5 clk = ~clk;

  sa48_slice_sequencer #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .opA(opA), .opB(opB), .ciIn(ciIn), .abort(abort),
    .inBusA(ba1), .inBusB(bb1),
    .threeNybblesFlag1(fl1[0]), .threeNybblesFlag2(fl1[1]),
    .threeNybblesFlag3(fl1[2]), .threeNybblesFlag4(fl1[3]),
    .loadReady(lr1), .ci48(ci1), .sumIn(sum1), .coIn(co1),
    .result(res1), .carryOut(cy1), .result_valid(rv1),
    .result_ready(result_ready), .busy(busy1)
  );

  sa48_slice_sequencer #(.HOLD_CYCLES(H3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv3), .start_ready(sr3),
    .opA(opA), .opB(opB), .ciIn(ciIn), .abort(abort),
    .inBusA(ba3), .inBusB(bb3),
    .threeNybblesFlag1(fl3[0]), .threeNybblesFlag2(fl3[1]),
    .threeNybblesFlag3(fl3[2]), .threeNybblesFlag4(fl3[3]),
    .loadReady(lr3), .ci48(ci3), .sumIn(sum3), .coIn(co3),
    .result(res3), .carryOut(cy3), .result_valid(rv3),
    .result_ready(result_ready), .busy(busy3)
  );

  // Datapath model: latches each flagged slice, adds the assembled 48-bit words.
  function automatic logic [48:0] dp_add(input logic [47:0] ca, input logic [47:0] cb,
                                         input logic [11:0] ba, input logic [11:0] bb,
                                         input logic [3:0] fl, input logic ci);
    logic [47:0] a;
    logic [47:0] b;
    a = ca;
    b = cb;
    for (int k = 0; k < 4; k++)
      if (fl[k]) begin
        a[12*k +: 12] = ba;
        b[12*k +: 12] = bb;
      end
    return {1'b0, a} + {1'b0, b} + 49'(ci);
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 4; k++) begin
      if (fl1[k]) begin capA1[12*k +: 12] <= ba1; capB1[12*k +: 12] <= bb1; end
      if (fl3[k]) begin capA3[12*k +: 12] <= ba3; capB3[12*k +: 12] <= bb3; end
    end

  assign dp1  = dp_add(capA1, capB1, ba1, bb1, fl1, ci1);
  assign dp3  = dp_add(capA3, capB3, ba3, bb3, fl3, ci3);
  assign sum1 = dp1[47:0];
  assign sum3 = dp3[47:0];
  assign co1  = (|fl1) ? dp1[48] : 1'b0;
  assign co3  = (|fl3) ? dp3[48] : 1'b0;

  logic        s_sr, s_lr, s_ci, s_cy, s_rv, s_busy;
  logic [3:0]  s_fl;
  logic [11:0] s_ba, s_bb;
  logic [47:0] s_res;

  always_comb begin
    s_sr   = sel ? sr3   : sr1;
    s_lr   = sel ? lr3   : lr1;
    s_ci   = sel ? ci3   : ci1;
    s_cy   = sel ? cy3   : cy1;
    s_rv   = sel ? rv3   : rv1;
    s_busy = sel ? busy3 : busy1;
    s_fl   = sel ? fl3   : fl1;
    s_ba   = sel ? ba3   : ba1;
    s_bb   = sel ? bb3   : bb1;
    s_res  = sel ? res3  : res1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s (H=%0d) got=%0h exp=%0h", tag, sel ? H3 : H1, got, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_start_ready", s_sr, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_flags", s_fl, 0);
    chk("rst_load_ready", s_lr, 0);
    chk("rst_ci48", s_ci, 0);
    chk("rst_result", s_res, 0);
    chk("rst_carry", s_cy, 0);
    chk("rst_result_valid", s_rv, 0);
    chk("rst_bus_a", s_ba, 0);
    chk("rst_bus_b", s_bb, 0);
  endtask

  // One operation; abort_t / rst_t interrupt it at that cycle, bp = DONE stall cycles.
  task automatic run_op(input bit s, input logic [47:0] a, input logic [47:0] b,
                        input logic ci, input int abort_t, input int rst_t, input int bp);
    int h;
    int k;
    logic [48:0] exp;
    logic [47:0] sha;
    logic [47:0] shb;
    h = s ? H3 : H1;
    sel = s;
    opA = a; opB = b; ciIn = ci; abort = 1'b0; result_ready = 1'b0;
    #1;
    chk("idle_start_ready", s_sr, 1);
    if (s) sv3 = 1'b1; else sv1 = 1'b1;
    @(posedge clk); #1;
    sv1 = 1'b0; sv3 = 1'b0;
    exp = {1'b0, a} + {1'b0, b} + 49'(ci);
    for (int t = 1; t <= 5 * h; t++) begin
      k = (t - 1) / h;
      sha = a >> (12 * k);
      shb = b >> (12 * k);
      chk("flags", s_fl, (k < 4) ? (64'd1 << k) : 64'd0);
      chk("load_ready", s_lr, (k == 4) ? 64'd1 : 64'd0);
      chk("bus_a", s_ba, (k < 4) ? {52'd0, sha[11:0]} : 64'd0);
      chk("bus_b", s_bb, (k < 4) ? {52'd0, shb[11:0]} : 64'd0);
      chk("ci48", s_ci, ci);
      chk("busy", s_busy, 1);
      chk("start_ready_busy", s_sr, 0);
      chk("result_valid_early", s_rv, 0);
      if (t == abort_t) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_flags", s_fl, 0);
        chk("abort_load_ready", s_lr, 0);
        chk("abort_idle", s_sr, 1);
        chk("abort_busy", s_busy, 0);
        repeat (3) begin
          chk("abort_no_valid", s_rv, 0);
          @(posedge clk); #1;
        end
        return;
      end
      if (t == rst_t) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_load_drop", s_lr, 0);
        chk_reset_state();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_start_ready", s_sr, 1);
        chk("post_rst_busy", s_busy, 0);
        return;
      end
      @(posedge clk); #1;
    end
    chk("result_valid", s_rv, 1);
    chk("result", s_res, exp[47:0]);
    chk("carry_out", s_cy, exp[48]);
    chk("done_ci48", s_ci, ci);
    chk("done_flags", s_fl, 0);
    chk("done_load_ready", s_lr, 0);
    chk("done_start_ready", s_sr, 0);
    repeat (bp) begin
      if (s) sv3 = 1'b1; else sv1 = 1'b1;
      opA = ~a;
      @(posedge clk); #1;
      chk("bp_valid", s_rv, 1);
      chk("bp_result", s_res, exp[47:0]);
      chk("bp_carry", s_cy, exp[48]);
      chk("bp_start_ready", s_sr, 0);
      chk("bp_flags", s_fl, 0);
    end
    sv1 = 1'b0; sv3 = 1'b0; opA = a;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("handshake_valid_low", s_rv, 0);
    chk("handshake_idle", s_sr, 1);
    chk("idle_ci48", s_ci, 0);
    chk("idle_busy", s_busy, 0);
  endtask

  initial begin
    logic [47:0] ra;
    logic [47:0] rb;
    #2;
    sel = 1'b0; #1; chk_reset_state();
    sel = 1'b1; #1; chk_reset_state();
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 48'h0000_0000_0001, 48'h0000_0000_0002, 1'b0, -1, -1, 0);
    run_op(1'b0, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, -1, -1, 0);
    rb = 48'({$urandom(), $urandom()});
    run_op(1'b1, 48'h444_333_222_111, rb, 1'b0, -1, -1, 0);
    ra = 48'({$urandom(), $urandom()});
    rb = 48'({$urandom(), $urandom()});
    run_op(1'b0, ra, rb, 1'b1, -1, -1, 10);
    run_op(1'b0, ra, rb, 1'b0, 2, -1, 0);
    run_op(1'b0, ra, rb, 1'b0, -1, -1, 0);
    run_op(1'b1, rb, ra, 1'b1, 5, -1, 0);
    run_op(1'b1, ra, rb, 1'b1, -1, 14, 0);
    run_op(1'b1, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, -1, -1, 2);

    for (int i = 0; i < 10; i++) begin
      ra = 48'({$urandom(), $urandom()});
      rb = 48'({$urandom(), $urandom()});
      run_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
             -1, -1, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
